seg7_scan_driver: RTL

//  Parametrised multiplexed driver for a common-anode/cathode multi-digit 7-segment display.

---
 rtl/seg7_scan_driver_if.sv | 24 ++
 rtl/seg7_scan_driver.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - datapath-side and pin-side signal bundle for the 7-segment scan driver
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_lz;
  logic                    enable;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output load, value, dp_in, blank_lz, enable,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  load, value, dp_in, blank_lz, enable,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed multi-digit hex 7-segment driver with double buffering
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_DIV     = 50000,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input logic                clk,
  input logic                reset,
  seg7_scan_driver_if.slave  bus
);
  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  // Pin levels meaning "off"; lit levels are these XOR'ed with an active-high pattern.
  localparam logic [6:0]            SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = (SEG_ACT_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [VAL_W-1:0]      pend_value;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [VAL_W-1:0]      act_value;
  logic [NUM_DIGITS-1:0] act_dp;

  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  frame_done_q;

  logic                  slot_end;
  logic                  wrap;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic [NUM_DIGITS-1:0] an_hot;
  logic                  upper_zero;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  // Slot/frame boundaries, current digit lookup and leading-zero mask.
  always_comb begin
    slot_end   = bus.enable && (cnt == CNT_MAX);
    wrap       = slot_end && (idx == IDX_MAX);
    cur_nib    = act_value[idx*4 +: 4];
    cur_dp     = act_dp[idx];
    an_hot     = NUM_DIGITS'(1) << idx;
    upper_zero = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero    = upper_zero && (act_value[4*i +: 4] == 4'h0);
      blank_mask[i] = bus.blank_lz && upper_zero && (i != 0);
    end
    cur_blank  = blank_mask[idx];
  end

  // Refresh prescaler and digit index; frozen while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (bus.enable) begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Double buffer: loads land in pending, frame wrap copies to active (a load on the wrap cycle goes straight through).
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_value <= '0;
      pend_dp    <= '0;
      act_value  <= '0;
      act_dp     <= '0;
    end else begin
      if (bus.load) begin
        pend_value <= bus.value;
        pend_dp    <= bus.dp_in;
      end
      if (wrap) begin
        act_value <= bus.load ? bus.value : pend_value;
        act_dp    <= bus.load ? bus.dp_in : pend_dp;
      end
    end
  end

  // Registered pin drive; cnt==0 is a dark guard slot so the previous digit's segments never ghost onto the next anode.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= wrap;
      if (!bus.enable || cnt == '0) begin
        seg_q <= SEG_OFF;
        dp_q  <= DP_OFF;
        an_q  <= AN_OFF;
      end else begin
        seg_q <= cur_blank ? SEG_OFF : (decode(cur_nib) ^ SEG_OFF);
        dp_q  <= cur_dp ^ DP_OFF;
        an_q  <= an_hot ^ AN_OFF;
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;
endmodule
